top_soc_pixel_capture: RTL and testbench
========================================

Name: top_soc_pixel_capture

Overview:
- Mode-selectable test-pattern pixel source plus the port-A frame-buffer write controller.
- On a START pulse it streams one MAX_ROW x MAX_COL 8-bit frame in row-major order, one pixel per clock.
- Each pixel is written into the dual-port frame BRAM's port A at a linear address.
- The BRAM's port B is drained by a separate display-side controller that is outside this block.

Parameters:
- MAX_ROW, 540, frame rows.
- MAX_COL, 540, frame columns.
- ADDR_W, 19, BRAM address width; must satisfy 2^ADDR_W >= MAX_ROW*MAX_COL.
- PIX_W, 8, pixel width.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- mode1_start_i  in  1  switch 1: select gradient pattern.
- mode2_start_i  in  1  switch 2: select checkerboard pattern.
- start_i  in  1  start request, rising-edge qualified.
- led1_on_o  out  1  mode-1 frame busy or done.
- led2_on_o  out  1  mode-2 frame busy or done.
- pixel_o  out  PIX_W  streamed pixel.
- pixel_en_o  out  1  pixel_o valid.
- ena_o  out  1  BRAM port-A enable.
- wea_o  out  1  BRAM port-A write enable (1 = write).
- addra_o  out  ADDR_W  BRAM port-A address.
- d2mema_o  out  PIX_W  BRAM port-A write data.
- mem2da_i  in  PIX_W  BRAM port-A read data; ignored, this block never reads.
- done_o  out  1  frame fully written.

Behaviour:
- Interface: one clock, clk. Reset rst_n is synchronous and active-low. All state is updated on the clk rising edge only.
- Reset: state IDLE; row, col, addra_o = 0; every output = 0; start_q = 0; latched mode = 0. Reset has priority over all other inputs, including mid-frame: the frame is abandoned, no further writes are issued, and done_o stays 0.
- Start detect: start_q <= start_i every cycle. A start_evt is start_i=1 && start_q=0.
- Mode validity: exactly one of mode1_start_i / mode2_start_i must be high. If both or neither are high, start_evt is ignored.
- States:
  - IDLE: a valid start_evt latches the mode and clears row, col and the address. Next state is STREAM.
  - STREAM: each cycle, register pixel_o = pattern(row,col) and pixel_en_o = 1, then advance col. On col == MAX_COL-1: col = 0 and row++. On the pixel (MAX_ROW-1, MAX_COL-1), the next state is DONE.
  - In STREAM, start_evt and mode switch changes are ignored.
  - DONE: pixel_en_o = 0; done_o = 1 once the final write has issued. A valid start_evt clears done_o and restarts STREAM from (0,0) at address 0.
- Latency: start_evt sampled at edge k gives the first pixel_en_o=1 after edge k+1. The first write (ena_o=wea_o=1, addra_o=0) appears after edge k+2.
- Stream length: pixel_en_o is high for exactly MAX_ROW*MAX_COL consecutive cycles, with no gaps.
- Patterns (8-bit, truncation mod 256):
  - Mode 1: pixel = (row + col)[7:0].
  - Mode 2: pixel = (row[3] ^ col[3]) ? 8'hFF : 8'h00.
- Write controller (registered one stage behind the pixel stream): ena_o <= pixel_en_o; wea_o <= pixel_en_o; d2mema_o <= pixel_o.
- Write address: addra_o holds the address of the write currently presented. It starts at 0 and increments by 1 after each write, so the final write is at MAX_ROW*MAX_COL-1 (291599 by default). After the final write the next-address counter wraps to 0.
- Outputs when not writing: ena_o = wea_o = 0 and addra_o holds its last value.
- done_o rises in the cycle after the final write and holds until the next valid start_evt or reset.
- LEDs: led1_on_o = (latched mode == 1) && state != IDLE. led2_on_o is the same for mode 2. Both LEDs are 0 after reset.
- Switch changes after the mode is latched do not affect the current frame.

Test Plan:
- Reset: hold rst_n=0 with mode1/mode2 toggling -> all outputs 0, no ena_o.
- Mode 1, MAX_ROW=MAX_COL=540: mode1=1, pulse start_i -> exactly 291600 writes with consecutive addresses 0..291599. Data checks: addr 0 = 0, addr 1 = 1, addr 540 = 1, addr 291599 = 54. done_o=1 and led1_on_o=1 afterwards.
- Mode 2, MAX_ROW=MAX_COL=16: address 8 = 0xFF, address 0 = 0x00, address 136 (row 8, col 8) = 0x00 -> 256 writes; led2_on_o=1, led1_on_o=0.
- Invalid and ignored starts: both switches high + start pulse -> no writes. A start_i held high for 40 cycles -> exactly one frame. A second pulse mid-frame -> ignored, write count unchanged.
- Reset mid-frame, then restart: assert rst_n=0 at write 1000 -> ena_o=0 on the next edge, done_o=0. Restart -> first write at addra_o=0 with the correct pattern.
- Restart from DONE: a new start_evt -> done_o falls and a second full frame is rewritten starting at address 0.

Source files
------------

// File: rtl/top_soc_pixel_capture.sv
// top_soc_pixel_capture: test-pattern pixel source feeding BRAM port-A frame writes
module top_soc_pixel_capture #(
    parameter int MAX_ROW = 540,
    parameter int MAX_COL = 540,
    parameter int ADDR_W  = 19,
    parameter int PIX_W   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mode1_start_i,
    input  logic              mode2_start_i,
    input  logic              start_i,
    output logic              led1_on_o,
    output logic              led2_on_o,
    output logic [PIX_W-1:0]  pixel_o,
    output logic              pixel_en_o,
    output logic              ena_o,
    output logic              wea_o,
    output logic [ADDR_W-1:0] addra_o,
    output logic [PIX_W-1:0]  d2mema_o,
    input  logic [PIX_W-1:0]  mem2da_i,
    output logic              done_o
);
    localparam int RW = ($clog2(MAX_ROW) < 4) ? 4 : $clog2(MAX_ROW);
    localparam int CW = ($clog2(MAX_COL) < 4) ? 4 : $clog2(MAX_COL);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MAX_ROW * MAX_COL - 1);

    typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

    state_t            state_q;
    logic [1:0]        mode_q;
    logic              start_q;
    logic [RW-1:0]     row_q;
    logic [CW-1:0]     col_q;
    logic [ADDR_W-1:0] addr_q;
    logic [PIX_W-1:0]  pixel_q;
    logic              pixel_en_q;
    logic              ena_q;
    logic              wea_q;
    logic [ADDR_W-1:0] addra_q;
    logic [PIX_W-1:0]  d2mema_q;
    logic              done_q;

    logic              start_evt;
    logic              last_col;
    logic              last_pix;
    logic [PIX_W-1:0]  pix_d;
    logic              unused_rd;

    assign unused_rd = ^mem2da_i;
    assign start_evt = start_i & ~start_q & (mode1_start_i ^ mode2_start_i);
    assign last_col  = col_q == CW'(MAX_COL - 1);
    assign last_pix  = last_col && row_q == RW'(MAX_ROW - 1);
    assign pix_d     = (mode_q == 2'd1) ? PIX_W'(row_q) + PIX_W'(col_q)
                                        : {PIX_W{row_q[3] ^ col_q[3]}};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            mode_q     <= '0;
            start_q    <= 1'b0;
            row_q      <= '0;
            col_q      <= '0;
            addr_q     <= '0;
            pixel_q    <= '0;
            pixel_en_q <= 1'b0;
            ena_q      <= 1'b0;
            wea_q      <= 1'b0;
            addra_q    <= '0;
            d2mema_q   <= '0;
            done_q     <= 1'b0;
        end else begin
            start_q  <= start_i;
            ena_q    <= pixel_en_q;
            wea_q    <= pixel_en_q;
            d2mema_q <= pixel_q;
            // write address trails the pixel stream by one stage
            if (pixel_en_q) begin
                addra_q <= addr_q;
                addr_q  <= (addr_q == LAST_ADDR) ? '0 : addr_q + ADDR_W'(1);
            end
            case (state_q)
                STREAM: begin
                    pixel_q    <= pix_d;
                    pixel_en_q <= 1'b1;
                    col_q      <= last_col ? '0 : col_q + CW'(1);
                    row_q      <= last_col ? row_q + RW'(1) : row_q;
                    state_q    <= last_pix ? DONE : STREAM;
                end
                default: begin
                    pixel_en_q <= 1'b0;
                    // the final write is presented while pixel_en is still high
                    if (state_q == DONE && !pixel_en_q)
                        done_q <= 1'b1;
                    if (start_evt) begin
                        mode_q  <= {mode2_start_i, mode1_start_i};
                        row_q   <= '0;
                        col_q   <= '0;
                        addr_q  <= '0;
                        done_q  <= 1'b0;
                        state_q <= STREAM;
                    end
                end
            endcase
        end
    end

    assign led1_on_o  = mode_q == 2'd1 && state_q != IDLE;
    assign led2_on_o  = mode_q == 2'd2 && state_q != IDLE;
    assign pixel_o    = pixel_q;
    assign pixel_en_o = pixel_en_q;
    assign ena_o      = ena_q;
    assign wea_o      = wea_q;
    assign addra_o    = addra_q;
    assign d2mema_o   = d2mema_q;
    assign done_o     = done_q;
endmodule

// File: tb/tb_top_soc_pixel_capture.sv
// tb_top_soc_pixel_capture: scoreboard bench for the pattern source and port-A writer
module tb_top_soc_pixel_capture;
    localparam int MR = 12;
    localparam int MC = 20;
    localparam int AW = 8;
    localparam int N  = MR * MC;

    typedef struct {
        logic [AW-1:0] a;
        logic [7:0]    d;
    } wr_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          mode1 = 1'b0;
    logic          mode2 = 1'b0;
    logic          start = 1'b0;
    logic          led1, led2, pixel_en, ena, wea, done;
    logic [7:0]    pixel, d2mema;
    logic [AW-1:0] addra;

    wr_t sb[$];
    int  n_cmp = 0;
    int  n_err = 0;
    int  n_writes = 0;

    top_soc_pixel_capture #(.MAX_ROW(MR), .MAX_COL(MC), .ADDR_W(AW), .PIX_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .mode1_start_i(mode1), .mode2_start_i(mode2),
        .start_i(start), .led1_on_o(led1), .led2_on_o(led2), .pixel_o(pixel),
        .pixel_en_o(pixel_en), .ena_o(ena), .wea_o(wea), .addra_o(addra),
        .d2mema_o(d2mema), .mem2da_i(8'h5A), .done_o(done)
    );

    always #5 clk = ~clk;

    // scoreboard consumer: every port-A write must match the next expected one
    always @(negedge clk) begin
        if (ena === 1'b1) begin
            n_writes++;
            n_cmp++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_write: addr %0d data %0h, none expected", addra, d2mema);
            end else begin
                wr_t e;
                e = sb.pop_front();
                if (addra !== e.a || d2mema !== e.d || wea !== 1'b1) begin
                    n_err++;
                    $display("FAIL write: got addr %0d data %0h wea %b, exp addr %0d data %0h wea 1",
                             addra, d2mema, wea, e.a, e.d);
                end
            end
        end
    end

    function automatic logic [7:0] pat(input int m, input int r, input int c);
        if (m == 1) return 8'((r + c) & 255);
        return ((((r >> 3) ^ (c >> 3)) & 1) != 0) ? 8'hFF : 8'h00;
    endfunction

    task automatic push_frame(input int m);
        wr_t w;
        for (int r = 0; r < MR; r++)
            for (int c = 0; c < MC; c++) begin
                w.a = AW'(r * MC + c);
                w.d = pat(m, r, c);
                sb.push_back(w);
            end
    endtask

    task automatic wait_done(input string name);
        int g = 0;
        while (done !== 1'b1 && g < 4 * N) begin
            @(negedge clk);
            g++;
        end
        n_cmp++;
        if (done !== 1'b1) begin
            n_err++;
            $display("FAIL %s_timeout: done_o %b after %0d cycles, exp 1", name, done, g);
        end
        repeat (3) @(negedge clk);
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL %s_pending: %0d writes outstanding, exp 0", name, sb.size());
        end
    endtask

    task automatic test_reset;
        logic [AW+22:0] o;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            mode1 = i[0];
            mode2 = i[1];
            start = i[0];
            o = {led1, led2, pixel, pixel_en, ena, wea, addra, d2mema, done};
            n_cmp++;
            if (o !== '0) begin
                n_err++;
                $display("FAIL reset_outputs: got %0h exp 0", o);
            end
        end
        @(negedge clk);
        start = 1'b0;
        mode1 = 1'b0;
        mode2 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_mode1;
        int cnt = 0;
        int g = 0;
        @(negedge clk);
        mode1 = 1'b1;
        mode2 = 1'b0;
        start = 1'b1;
        push_frame(1);
        @(negedge clk);
        start = 1'b0;
        n_cmp++;
        if (pixel_en !== 1'b0) begin
            n_err++;
            $display("FAIL lat_k: pixel_en_o %b exp 0", pixel_en);
        end
        @(negedge clk);
        n_cmp++;
        if (pixel_en !== 1'b1 || ena !== 1'b0 || pixel !== 8'h00) begin
            n_err++;
            $display("FAIL lat_k1: pixel_en %b ena %b pixel %0h exp 1 0 0", pixel_en, ena, pixel);
        end
        @(negedge clk);
        n_cmp++;
        if (ena !== 1'b1 || addra !== '0) begin
            n_err++;
            $display("FAIL lat_k2: ena %b addr %0d exp 1 0", ena, addra);
        end
        while (ena === 1'b1 && g < N + 10) begin
            cnt++;
            g++;
            @(negedge clk);
        end
        n_cmp++;
        if (cnt != N) begin
            n_err++;
            $display("FAIL stream_len: got %0d consecutive writes exp %0d", cnt, N);
        end
        n_cmp++;
        if (done !== 1'b1 || addra !== AW'(N - 1) || led1 !== 1'b1 || led2 !== 1'b0) begin
            n_err++;
            $display("FAIL mode1_end: done %b addr %0d led1 %b led2 %b exp 1 %0d 1 0",
                     done, addra, led1, led2, N - 1);
        end
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL mode1_pending: %0d writes outstanding exp 0", sb.size());
        end
    endtask

    task automatic test_mode2_restart;
        @(negedge clk);
        mode1 = 1'b0;
        mode2 = 1'b1;
        start = 1'b1;
        push_frame(2);
        @(negedge clk);
        start = 1'b0;
        n_cmp++;
        if (done !== 1'b0 || led2 !== 1'b1 || led1 !== 1'b0) begin
            n_err++;
            $display("FAIL restart: done %b led2 %b led1 %b exp 0 1 0", done, led2, led1);
        end
        wait_done("mode2");
        n_cmp++;
        if (led2 !== 1'b1 || led1 !== 1'b0) begin
            n_err++;
            $display("FAIL mode2_leds: led2 %b led1 %b exp 1 0", led2, led1);
        end
    endtask

    task automatic test_invalid;
        int w0 = n_writes;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            mode1 = (i == 0);
            mode2 = (i == 0);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        repeat (20) @(negedge clk);
        n_cmp++;
        if (n_writes != w0 || done !== 1'b1 || pixel_en !== 1'b0) begin
            n_err++;
            $display("FAIL invalid_start: writes %0d done %b pixel_en %b exp 0 1 0",
                     n_writes - w0, done, pixel_en);
        end
    endtask

    task automatic test_held_start;
        int w0 = n_writes;
        @(negedge clk);
        mode1 = 1'b1;
        mode2 = 1'b0;
        start = 1'b1;
        push_frame(1);
        repeat (40) @(negedge clk);
        start = 1'b0;
        mode1 = 1'b0;
        mode2 = 1'b1;
        repeat (10) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("held");
        n_cmp++;
        if (n_writes - w0 != N || led1 !== 1'b1) begin
            n_err++;
            $display("FAIL held_start: got %0d writes led1 %b exp %0d 1", n_writes - w0, led1, N);
        end
    endtask

    task automatic test_reset_mid;
        int w0 = n_writes;
        int g = 0;
        @(negedge clk);
        mode1 = 1'b0;
        mode2 = 1'b1;
        start = 1'b1;
        push_frame(2);
        @(negedge clk);
        start = 1'b0;
        while (n_writes - w0 < 100 && g < 4 * N) begin
            @(negedge clk);
            g++;
        end
        rst_n = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (ena !== 1'b0 || done !== 1'b0 || pixel_en !== 1'b0 || led2 !== 1'b0 || n_writes - w0 < 100) begin
            n_err++;
            $display("FAIL reset_mid: ena %b done %b pixel_en %b led2 %b writes %0d exp 0 0 0 0 >=100",
                     ena, done, pixel_en, led2, n_writes - w0);
        end
        sb.delete();
        w0 = n_writes;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        n_cmp++;
        if (n_writes != w0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL post_reset_idle: writes %0d done %b exp 0 0", n_writes - w0, done);
        end
        mode1 = 1'b1;
        mode2 = 1'b0;
        start = 1'b1;
        push_frame(1);
        @(negedge clk);
        start = 1'b0;
        wait_done("after_reset");
        n_cmp++;
        if (n_writes - w0 != N) begin
            n_err++;
            $display("FAIL after_reset_count: got %0d writes exp %0d", n_writes - w0, N);
        end
    endtask

    initial begin
        test_reset();
        test_mode1();
        test_mode2_restart();
        test_invalid();
        test_held_start();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
